uart_pkt_ctrl: RTL and testbench

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_pkt_buf.sv | 25 ++
 rtl/uart_pkt_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet controller: framing constant,
// FSM state encoding and default payload depth.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE           = 8'hA5;
    localparam int         DEFAULT_MAX_PAYLOAD = 16;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_e;

    // Address width for an n-entry register file; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
// Contents are not reset; readers only look at entries written for the current packet.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Packet framer for a UART byte stream: SYNC, LEN, payload, XOR checksum.
// Validated payloads are buffered and then drained downstream with valid/ready.
module uart_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_PAYLOAD    = DEFAULT_MAX_PAYLOAD,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       uart_clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int IW = idx_w(MAX_PAYLOAD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    xor_q, xor_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_ovr_q, err_ovr_d;

    logic       buf_we;
    logic [7:0] buf_rdata;
    logic       tmo_hit;
    logic       counting;
    logic       xfer;

    assign buf_we   = (state_q == S_PAYLOAD) && rx_data_ready;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign counting = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign xfer     = out_valid && out_ready;

    uart_pkt_buf #(
        .DEPTH (MAX_PAYLOAD),
        .IW    (IW)
    ) u_buf (
        .clk_i   (uart_clk),
        .we_i    (buf_we),
        .waddr_i (wr_idx_q[IW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (rd_idx_q[IW-1:0]),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HUNT;
            len_q     <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            tmo_q     <= '0;
            xor_q     <= '0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            tmo_q     <= tmo_d;
            xor_q     <= xor_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        xor_d     = xor_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        // Any received byte wins over expiry; the counter only runs while waiting for one.
        tmo_d     = (counting && !rx_data_ready && !tmo_hit) ? tmo_q + TW'(1) : '0;

        case (state_q)
            S_HUNT: begin
                if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
                    state_d  = S_LEN;
                    wr_idx_d = '0;
                    rd_idx_d = '0;
                end
            end
            S_LEN: begin
                if (rx_data_ready) begin
                    if ((rx_data == 8'd0) || (rx_data > 8'(MAX_PAYLOAD))) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        len_d   = rx_data[CW-1:0];
                        xor_d   = rx_data;
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (rx_data_ready) begin
                    xor_d    = xor_q ^ rx_data;
                    wr_idx_d = wr_idx_q + CW'(1);
                    if (wr_idx_q == len_q - CW'(1)) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end
            end
            S_CHECK: begin
                if (rx_data_ready) begin
                    if (rx_data == xor_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end
            end
            S_DRAIN: begin
                err_ovr_d = rx_data_ready;
                if (xfer) begin
                    rd_idx_d = rd_idx_q + CW'(1);
                    if (out_last) begin
                        state_d = S_HUNT;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    assign out_valid   = (state_q == S_DRAIN);
    assign out_last    = out_valid && (rd_idx_q == len_q - CW'(1));
    assign out_data    = out_valid ? buf_rdata : '0;
    assign busy        = (state_q != S_HUNT);
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Scoreboard bench for uart_pkt_ctrl: expected payload bytes are queued as packets
// are sent and checked as the DUT hands them downstream.
module tb_uart_pkt_ctrl;
    import uart_pkg::*;

    localparam int MAXP = 16;
    localparam int TMO  = 32;

    logic       uart_clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       err_chk, err_len, err_timeout, err_overrun, busy;

    always #5 uart_clk = ~uart_clk;

    uart_pkt_ctrl #(
        .MAX_PAYLOAD    (MAXP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .uart_clk      (uart_clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .err_chk       (err_chk),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];    // {last, data}
    int n_chk_p = 0, n_len_p = 0, n_tmo_p = 0, n_ovr_p = 0, n_valid_cyc = 0;
    int b_chk, b_len, b_tmo, b_ovr, b_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge uart_clk) begin
        if (reset_n) begin
            if (err_chk)     n_chk_p++;
            if (err_len)     n_len_p++;
            if (err_timeout) n_tmo_p++;
            if (err_overrun) n_ovr_p++;
            if (out_valid)   n_valid_cyc++;
            if (out_valid && out_ready) begin
                check_eq("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_eq("out_data", 32'(out_data), 32'(e[7:0]));
                    check_eq("out_last", 32'(out_last), 32'(e[8]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge uart_clk);
        #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic snap();
        b_chk = n_chk_p;
        b_len = n_len_p;
        b_tmo = n_tmo_p;
        b_ovr = n_ovr_p;
        b_val = n_valid_cyc;
    endtask

    task automatic check_errs(input string tag, input int c, input int l, input int t, input int o);
        check_eq({tag, "_err_chk"},     32'(n_chk_p - b_chk), 32'(c));
        check_eq({tag, "_err_len"},     32'(n_len_p - b_len), 32'(l));
        check_eq({tag, "_err_timeout"}, 32'(n_tmo_p - b_tmo), 32'(t));
        check_eq({tag, "_err_overrun"}, 32'(n_ovr_p - b_ovr), 32'(o));
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_last"},  32'(out_last),  32'd0);
        check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_errs"},      32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);
    endtask

    initial begin
        logic [7:0] pl [$];
        logic [7:0] x;

        reset_n       = 1'b0;
        rx_data       = '0;
        rx_data_ready = 1'b0;
        out_ready     = 1'b1;
        @(negedge uart_clk);
        check_idle_outputs("reset");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Noise in HUNT is ignored, then a good 3-byte packet drains back to back.
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        @(negedge uart_clk);
        check_eq("noise_busy", 32'(busy), 32'd0);
        push_exp(8'h11, 1'b0);
        push_exp(8'h22, 1'b0);
        push_exp(8'h33, 1'b1);
        send_byte(SYNC_BYTE);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);    // 03^11^22^33
        @(negedge uart_clk);
        check_eq("p1_valid0", 32'(out_valid), 32'd1);
        check_eq("p1_data0",  32'(out_data),  32'h11);
        @(negedge uart_clk);
        check_eq("p1_data1",  32'(out_data),  32'h22);
        @(negedge uart_clk);
        check_eq("p1_data2",  32'(out_data),  32'h33);
        check_eq("p1_last2",  32'(out_last),  32'd1);
        @(negedge uart_clk);
        check_eq("p1_valid_end", 32'(out_valid), 32'd0);
        check_eq("p1_busy_end",  32'(busy),      32'd0);
        wait_drain("p1");
        check_errs("p1", 0, 0, 0, 0);

        // Checksum of 00 excludes LEN, so it must be rejected.
        snap();
        send_byte(SYNC_BYTE);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h00);
        tick(3);
        check_errs("chk00", 1, 0, 0, 0);

        // Bad checksum: packet discarded, busy drops right after CHK.
        snap();
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hFF);
        @(negedge uart_clk);
        check_eq("badchk_busy", 32'(busy), 32'd0);
        tick(4);
        check_errs("badchk", 1, 0, 0, 0);
        check_eq("badchk_valid_cycles", 32'(n_valid_cyc - b_val), 32'd0);

        // Length bounds: 0 and MAXP+1 are rejected.
        snap();
        send_byte(SYNC_BYTE);
        send_byte(8'h00);
        @(negedge uart_clk);
        check_eq("len0_busy", 32'(busy), 32'd0);
        send_byte(SYNC_BYTE);
        send_byte(8'(MAXP + 1));
        @(negedge uart_clk);
        check_eq("lenmax1_busy", 32'(busy), 32'd0);
        tick(2);
        check_errs("len", 0, 2, 0, 0);

        // Timeout boundary: still busy on the expiry cycle, idle one cycle later.
        snap();
        send_byte(SYNC_BYTE);
        send_byte(8'h04);
        send_byte(8'h01);
        tick(TMO - 1);
        @(negedge uart_clk);
        check_eq("tmo_busy_before", 32'(busy), 32'd1);
        check_eq("tmo_err_before",  32'(err_timeout), 32'd0);
        tick(1);
        @(negedge uart_clk);
        check_eq("tmo_busy_after", 32'(busy), 32'd0);
        check_eq("tmo_err_after",  32'(err_timeout), 32'd1);
        tick(TMO + 4);
        check_errs("tmo", 0, 0, 1, 0);

        snap();
        push_exp(8'hAB, 1'b0);
        push_exp(8'hCD, 1'b1);
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h64);
        wait_drain("post_tmo");
        check_errs("post_tmo", 0, 0, 0, 0);

        // A byte arriving on the expiry cycle is accepted.
        snap();
        push_exp(8'h01, 1'b0);
        push_exp(8'h02, 1'b0);
        push_exp(8'h03, 1'b0);
        push_exp(8'h04, 1'b1);
        send_byte(SYNC_BYTE);
        send_byte(8'h04);
        send_byte(8'h01);
        tick(TMO - 1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h00);
        wait_drain("bytewin");
        check_errs("bytewin", 0, 0, 0, 0);

        // Maximum length packet.
        snap();
        pl.delete();
        x = 8'(MAXP);
        for (int i = 0; i < MAXP; i++) begin
            pl.push_back(8'(i * 7 + 3));
            x = x ^ pl[i];
            push_exp(pl[i], i == MAXP - 1);
        end
        send_byte(SYNC_BYTE);
        send_byte(8'(MAXP));
        for (int i = 0; i < MAXP; i++) send_byte(pl[i]);
        send_byte(x);
        wait_drain("maxlen");
        check_errs("maxlen", 0, 0, 0, 0);

        // Backpressure with an overrun byte during drain.
        snap();
        out_ready = 1'b0;
        push_exp(8'h5A, 1'b0);
        push_exp(8'hC3, 1'b1);
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_byte(8'h9B);
        @(negedge uart_clk);
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_data",  32'(out_data),  32'h5A);
        send_byte(SYNC_BYTE);
        @(negedge uart_clk);
        check_eq("ovr_pulse", 32'(err_overrun), 32'd1);
        tick(3);
        @(negedge uart_clk);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_data",  32'(out_data),  32'h5A);
        check_eq("bp_hold_last",  32'(out_last),  32'd0);
        tick(1);
        out_ready = 1'b1;
        wait_drain("bp");
        tick(1);
        check_eq("bp_busy_end", 32'(busy), 32'd0);
        check_errs("bp", 0, 0, 0, 1);

        // Asynchronous reset mid-payload, then a single-byte packet.
        snap();
        send_byte(SYNC_BYTE);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #3;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        tick(2);
        reset_n = 1'b1;
        tick(TMO + 4);
        check_errs("async_rst", 0, 0, 0, 0);

        snap();
        push_exp(8'h7E, 1'b1);
        send_byte(SYNC_BYTE);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7F);
        wait_drain("len1");
        check_errs("len1", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
